// File: rtl/display_pkg.sv
// Shared definitions for the display register block.
// Register map, CTRL field positions and segment decode.
package display_pkg;

  typedef logic [7:0] seg_t;

  localparam logic [2:0] A_CTRL   = 3'd0;
  localparam logic [2:0] A_PWM    = 3'd1;
  localparam logic [2:0] A_VALUE  = 3'd2;
  localparam logic [2:0] A_DP     = 3'd3;
  localparam logic [2:0] A_PUSH   = 3'd4;
  localparam logic [2:0] A_SDIV   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_CLEAR  = 3'd7;

  localparam int CTRL_HEX    = 4;
  localparam int CTRL_SCROLL = 5;

  // mode=3, brightness=3, hex/scroll off
  localparam logic [5:0] CTRL_RST = 6'h0F;

  function automatic seg_t hexseg(input logic [3:0] n);
    seg_t s;
    unique case (n)
      4'h0: s = 8'h3F;
      4'h1: s = 8'h06;
      4'h2: s = 8'h5B;
      4'h3: s = 8'h4F;
      4'h4: s = 8'h66;
      4'h5: s = 8'h6D;
      4'h6: s = 8'h7D;
      4'h7: s = 8'h07;
      4'h8: s = 8'h7F;
      4'h9: s = 8'h6F;
      4'hA: s = 8'h77;
      4'hB: s = 8'h7C;
      4'hC: s = 8'h39;
      4'hD: s = 8'h5E;
      4'hE: s = 8'h79;
      4'hF: s = 8'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/display_if.sv
// CPU-side register bus for display_ctrl.
// Single-cycle strobes, registered ack and read data.
interface display_if;
  logic        wr_en;
  logic        rd_en;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ack;

  modport master (
    output wr_en, rd_en, addr, wdata,
    input  rdata, ack
  );

  modport slave (
    input  wr_en, rd_en, addr, wdata,
    output rdata, ack
  );
endinterface

// File: rtl/char_ring.sv
// Circular character buffer with sticky overflow flag.
// Read ports take an offset from the oldest entry.
module char_ring
  import display_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NRD   = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  seg_t               push_data,
  input  logic               clear,
  input  logic [NRD*AW-1:0]  rd_off,
  output seg_t [NRD-1:0]     rd_data,
  output logic [CW-1:0]      count,
  output logic               full,
  output logic               empty,
  output logic               overflow
);

  seg_t          mem_q [DEPTH];
  seg_t          mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  assign count    = cnt_q;
  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  assign overflow = ovf_q;

  // clear beats push; a push into a full ring only sets overflow
  always_comb begin
    mem_d  = mem_q;
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    if (clear) begin
      head_d = '0;
      tail_d = '0;
      cnt_d  = '0;
      ovf_d  = 1'b0;
    end else if (push) begin
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        mem_d[tail_q] = push_data;
        tail_d        = tail_q + 1'b1;
        cnt_d         = cnt_q + 1'b1;
      end
    end
  end

  // ring state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      mem_q  <= mem_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
    end
  end

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0] idx;
    assign idx        = head_q + rd_off[g*AW +: AW];
    assign rd_data[g] = mem_q[idx];
  end

endmodule

// File: rtl/display_ctrl.sv
// Register block feeding display_driver.
// Hex, raw-buffer and auto-scroll content modes.
module display_ctrl
  import display_pkg::*;
#(
  parameter int BUF_DEPTH = 8,
  parameter int DIV_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  display_if.slave    bus,
  output logic [31:0] display_data,
  output logic [15:0] pwm_period,
  output logic [1:0]  brightness,
  output logic [1:0]  display_mode
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;

  logic [5:0]       ctrl_q, ctrl_d;
  logic [15:0]      pwm_q, pwm_d;
  logic [15:0]      value_q, value_d;
  logic [3:0]       dp_q, dp_d;
  logic [DIV_W-1:0] sdiv_q, sdiv_d;
  logic [DIV_W-1:0] divc_q, divc_d;
  logic [AW-1:0]    pos_q, pos_d;
  logic             ack_q, ack_d;
  logic [15:0]      rdata_q, rdata_d;
  logic [31:0]      disp_q, disp_d;
  logic [15:0]      pwm_o_q, pwm_o_d;
  logic [1:0]       bri_o_q, bri_o_d;
  logic [1:0]       mode_o_q, mode_o_d;

  logic             push, clr;
  logic [4*AW-1:0]  rd_off;
  seg_t [3:0]       rd_data;
  logic [CW-1:0]    cnt;
  logic             full, empty, ovf;
  logic             scroll_on, step_en;
  logic [CW-1:0]    sum;
  logic [15:0]      rd_val;
  seg_t             dig;

  assign push = bus.wr_en && (bus.addr == A_PUSH);
  assign clr  = bus.wr_en && (bus.addr == A_CLEAR);

  char_ring #(.DEPTH(BUF_DEPTH), .NRD(4)) u_ring (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (bus.wdata[7:0]),
    .clear     (clr),
    .rd_off    (rd_off),
    .rd_data   (rd_data),
    .count     (cnt),
    .full      (full),
    .empty     (empty),
    .overflow  (ovf)
  );

  assign scroll_on = ctrl_q[CTRL_SCROLL] && (cnt != '0);
  assign step_en   = ctrl_q[CTRL_SCROLL] && (cnt > CW'(4))
                     && (sdiv_q != '0);

  // register file writes; STATUS is read-only
  always_comb begin
    ctrl_d  = ctrl_q;
    pwm_d   = pwm_q;
    value_d = value_q;
    dp_d    = dp_q;
    sdiv_d  = sdiv_q;
    if (bus.wr_en) begin
      case (bus.addr)
        A_CTRL:  ctrl_d  = bus.wdata[5:0];
        A_PWM:   pwm_d   = bus.wdata;
        A_VALUE: value_d = bus.wdata;
        A_DP:    dp_d    = bus.wdata[3:0];
        A_SDIV:  sdiv_d  = bus.wdata[DIV_W-1:0];
        default: ;
      endcase
    end
  end

  // read mux samples pre-write state; rdata holds between reads
  always_comb begin
    rd_val = '0;
    case (bus.addr)
      A_CTRL:   rd_val = {10'b0, ctrl_q};
      A_PWM:    rd_val = pwm_q;
      A_VALUE:  rd_val = value_q;
      A_DP:     rd_val = {12'b0, dp_q};
      A_SDIV:   rd_val = 16'(sdiv_q);
      A_STATUS: rd_val = {9'b0, ovf, empty, full, 4'(cnt)};
      default:  rd_val = '0;
    endcase
    ack_d   = bus.wr_en || bus.rd_en;
    rdata_d = bus.rd_en ? rd_val : rdata_q;
  end

  // divider and scroll position; pos always stays below count
  always_comb begin
    divc_d = divc_q;
    pos_d  = pos_q;
    if (clr) begin
      divc_d = '0;
      pos_d  = '0;
    end else if (bus.wr_en && (bus.addr == A_SDIV)) begin
      divc_d = '0;
    end else if (!step_en) begin
      divc_d = '0;
    end else if (divc_q == sdiv_q - 1'b1) begin
      divc_d = '0;
      pos_d  = ({1'b0, pos_q} + 1'b1 == cnt) ? '0 : pos_q + 1'b1;
    end else begin
      divc_d = divc_q + 1'b1;
    end
  end

  // ring offsets per slot: rotated by pos when scrolling
  always_comb begin
    rd_off = '0;
    sum    = '0;
    for (int k = 0; k < 4; k++) begin
      sum = {1'b0, pos_q} + CW'(k);
      if (sum >= cnt) sum = sum - cnt;
      rd_off[k*AW +: AW] = scroll_on ? sum[AW-1:0] : AW'(k);
    end
  end

  // compose next display word; slot k drives digit 3-k
  always_comb begin
    disp_d = '0;
    dig    = '0;
    for (int k = 0; k < 4; k++) begin
      if (scroll_on || !ctrl_q[CTRL_HEX]) begin
        dig = (CW'(k) < cnt) ? rd_data[k] : '0;
      end else begin
        dig = hexseg(value_q[4*(3-k) +: 4]);
      end
      disp_d[8*(3-k) +: 8] = dig | {dp_q[3-k], 7'b0};
    end
    pwm_o_d  = pwm_q;
    bri_o_d  = ctrl_q[3:2];
    mode_o_d = ctrl_q[1:0];
  end

  // all architectural and output state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_q   <= CTRL_RST;
      pwm_q    <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      sdiv_q   <= '0;
      divc_q   <= '0;
      pos_q    <= '0;
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      disp_q   <= '0;
      pwm_o_q  <= '0;
      bri_o_q  <= 2'b11;
      mode_o_q <= 2'b11;
    end else begin
      ctrl_q   <= ctrl_d;
      pwm_q    <= pwm_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      sdiv_q   <= sdiv_d;
      divc_q   <= divc_d;
      pos_q    <= pos_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
      disp_q   <= disp_d;
      pwm_o_q  <= pwm_o_d;
      bri_o_q  <= bri_o_d;
      mode_o_q <= mode_o_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.rdata    = rdata_q;
  assign display_data = disp_q;
  assign pwm_period   = pwm_o_q;
  assign brightness   = bri_o_q;
  assign display_mode = mode_o_q;

endmodule

// File: tb/tb_display_ctrl.sv
// Self-checking bench for display_ctrl.
// Reference model: byte queue plus register shadows.
module tb_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] display_data;
  logic [15:0] pwm_period;
  logic [1:0]  brightness;
  logic [1:0]  display_mode;

  display_if bus ();

  display_ctrl #(.BUF_DEPTH(8), .DIV_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .display_data (display_data),
    .pwm_period   (pwm_period),
    .brightness   (brightness),
    .display_mode (display_mode)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  hex_tab [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  logic [7:0]  q [$];
  logic        m_ovf;
  logic [5:0]  m_ctrl;
  logic [15:0] m_val, m_pwm, m_sdiv;
  logic [3:0]  m_dp;
  int          m_pos;

  function automatic void model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_ctrl = 6'h0F;
    m_val  = '0;
    m_pwm  = '0;
    m_sdiv = '0;
    m_dp   = '0;
    m_pos  = 0;
  endfunction

  function automatic logic [15:0] model_status();
    int c;
    c = q.size();
    return {9'b0, m_ovf, c == 0, c == 8, 4'(c)};
  endfunction

  function automatic void model_write(input logic [2:0] a,
                                      input logic [15:0] d);
    case (a)
      3'd0: m_ctrl = d[5:0];
      3'd1: m_pwm  = d;
      3'd2: m_val  = d;
      3'd3: m_dp   = d[3:0];
      3'd4: if (q.size() < 8) q.push_back(d[7:0]); else m_ovf = 1'b1;
      3'd5: m_sdiv = d;
      3'd7: begin q.delete(); m_ovf = 1'b0; m_pos = 0; end
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] model_read(input logic [2:0] a);
    case (a)
      3'd0: return {10'b0, m_ctrl};
      3'd1: return m_pwm;
      3'd2: return m_val;
      3'd3: return {12'b0, m_dp};
      3'd5: return m_sdiv;
      3'd6: return model_status();
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [31:0] model_disp();
    int c;
    logic [31:0] r;
    logic [7:0]  d;
    c = q.size();
    r = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_ctrl[5] && c > 0) d = (k < c) ? q[(m_pos + k) % c] : 8'h00;
      else if (m_ctrl[4]) d = hex_tab[m_val[4*(3-k) +: 4]];
      else d = (k < c) ? q[k] : 8'h00;
      r[8*(3-k) +: 8] = d | (m_dp[3-k] ? 8'h80 : 8'h00);
    end
    return r;
  endfunction

  task automatic bus_op(input logic w, input logic r,
                        input logic [2:0] a, input logic [15:0] d,
                        output logic ackv, output logic [15:0] rv);
    @(negedge clk);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.addr  = a;
    bus.wdata = d;
    @(posedge clk);
    #1;
    ackv = bus.ack;
    rv   = bus.rdata;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    if (w) model_write(a, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic ackv;
    logic [15:0] rv;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (display_data !== 32'h0) begin
      n_bad++; $display("FAIL rst_disp: got %h want 0", display_data);
    end
    n_cmp++;
    if (display_mode !== 2'b11 || brightness !== 2'b11) begin
      n_bad++; $display("FAIL rst_mode_bri: got %b/%b want 11/11",
                        display_mode, brightness);
    end
    n_cmp++;
    if (pwm_period !== 16'h0 || bus.ack !== 1'b0) begin
      n_bad++; $display("FAIL rst_pwm_ack: got %h/%b want 0/0",
                        pwm_period, bus.ack);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (ackv !== 1'b1 || rv !== 16'h0020) begin
      n_bad++; $display("FAIL rst_status: got ack=%b %h want 1 0020",
                        ackv, rv);
    end
  endtask

  task automatic test_hex();
    logic ackv;
    logic [15:0] rv;
    bus_op(1'b1, 1'b0, 3'd0, 16'h001F, ackv, rv);
    n_cmp++;
    if (ackv !== 1'b1) begin
      n_bad++; $display("FAIL hex_ack_ctrl: got %b want 1", ackv);
    end
    bus_op(1'b1, 1'b0, 3'd2, 16'h1A3F, ackv, rv);
    n_cmp++;
    if (ackv !== 1'b1) begin
      n_bad++; $display("FAIL hex_ack_val: got %b want 1", ackv);
    end
    bus_op(1'b1, 1'b0, 3'd3, 16'h0004, ackv, rv);
    n_cmp++;
    if (ackv !== 1'b1 || display_data !== 32'h06774F71) begin
      n_bad++; $display("FAIL hex_pre_dp: got ack=%b %h want 1 06774F71",
                        ackv, display_data);
    end
    tick();
    n_cmp++;
    if (display_data !== 32'h06F74F71) begin
      n_bad++; $display("FAIL hex_disp: got %h want 06F74F71",
                        display_data);
    end
    n_cmp++;
    if (display_data !== model_disp()) begin
      n_bad++; $display("FAIL hex_model: got %h want %h",
                        display_data, model_disp());
    end
    n_cmp++;
    if (bus.ack !== 1'b0) begin
      n_bad++; $display("FAIL hex_ack_pulse: got %b want 0", bus.ack);
    end
  endtask

  task automatic test_raw();
    logic ackv;
    logic [15:0] rv;
    bus_op(1'b1, 1'b0, 3'd0, 16'h000F, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd3, 16'h0000, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd7, 16'h0000, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd4, 16'h0076, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd4, 16'h0079, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd4, 16'h0038, ackv, rv);
    tick();
    n_cmp++;
    if (display_data !== 32'h76793800) begin
      n_bad++; $display("FAIL raw_disp: got %h want 76793800",
                        display_data);
    end
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h0003) begin
      n_bad++; $display("FAIL raw_status: got %h want 0003", rv);
    end
    bus_op(1'b0, 1'b1, 3'd4, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h0000) begin
      n_bad++; $display("FAIL raw_push_read: got %h want 0000", rv);
    end
  endtask

  task automatic test_rw_same();
    logic ackv;
    logic [15:0] rv, exp;
    exp = model_read(3'd2);
    bus_op(1'b1, 1'b1, 3'd2, 16'hBEEF, ackv, rv);
    n_cmp++;
    if (ackv !== 1'b1 || rv !== exp) begin
      n_bad++; $display("FAIL rw_same: got ack=%b %h want 1 %h",
                        ackv, rv, exp);
    end
    bus_op(1'b1, 1'b0, 3'd1, 16'h0321, ackv, rv);
    n_cmp++;
    if (rv !== exp) begin
      n_bad++; $display("FAIL rdata_hold: got %h want %h", rv, exp);
    end
    bus_op(1'b0, 1'b1, 3'd2, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'hBEEF) begin
      n_bad++; $display("FAIL rw_after: got %h want BEEF", rv);
    end
    tick();
    n_cmp++;
    if (pwm_period !== 16'h0321) begin
      n_bad++; $display("FAIL pwm_out: got %h want 0321", pwm_period);
    end
  endtask

  task automatic setup_scroll(input logic [15:0] sdiv);
    logic ackv;
    logic [15:0] rv;
    bus_op(1'b1, 1'b0, 3'd0, 16'h000F, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd3, 16'h0000, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd7, 16'h0000, ackv, rv);
    for (int i = 1; i <= 6; i++)
      bus_op(1'b1, 1'b0, 3'd4, 16'(i), ackv, rv);
    bus_op(1'b1, 1'b0, 3'd5, sdiv, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd0, 16'h002F, ackv, rv);
  endtask

  task automatic test_scroll();
    logic [31:0] fixed;
    setup_scroll(16'd4);
    for (int j = 1; j <= 25; j++) begin
      tick();
      m_pos = ((j - 1) / 4) % 6;
      n_cmp++;
      if (display_data !== model_disp()) begin
        n_bad++; $display("FAIL scroll_c%0d: got %h want %h",
                          j, display_data, model_disp());
      end
      fixed = 32'h0;
      if (j == 1 || j == 25) fixed = 32'h01020304;
      if (j == 5) fixed = 32'h02030405;
      if (j == 24) fixed = 32'h06010203;
      if (fixed != 32'h0) begin
        n_cmp++;
        if (display_data !== fixed) begin
          n_bad++; $display("FAIL scroll_fix_c%0d: got %h want %h",
                            j, display_data, fixed);
        end
      end
    end
  endtask

  task automatic test_sdiv_zero();
    logic ackv;
    logic [15:0] rv;
    int bad;
    setup_scroll(16'd4);
    repeat (5) tick();
    bus_op(1'b1, 1'b0, 3'd5, 16'h0000, ackv, rv);
    m_pos = 1;
    bad = 0;
    for (int j = 0; j < 100; j++) begin
      tick();
      n_cmp++;
      if (display_data !== model_disp()) begin
        n_bad++;
        if (bad < 4)
          $display("FAIL sdiv0_c%0d: got %h want %h",
                   j, display_data, model_disp());
        bad++;
      end
    end
    n_cmp++;
    if (display_data !== 32'h02030405) begin
      n_bad++; $display("FAIL sdiv0_fix: got %h want 02030405",
                        display_data);
    end
  endtask

  task automatic test_overflow();
    logic ackv;
    logic [15:0] rv;
    bus_op(1'b1, 1'b0, 3'd0, 16'h000F, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd7, 16'h0000, ackv, rv);
    for (int i = 0; i < 9; i++)
      bus_op(1'b1, 1'b0, 3'd4, 16'($urandom_range(1, 255)), ackv, rv);
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h0058) begin
      n_bad++; $display("FAIL ovf_status: got %h want 0058", rv);
    end
    bus_op(1'b1, 1'b0, 3'd5, 16'd1, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd0, 16'h002F, ackv, rv);
    for (int j = 1; j <= 9; j++) begin
      tick();
      m_pos = (j - 1) % 8;
      n_cmp++;
      if (display_data !== model_disp()) begin
        n_bad++; $display("FAIL ovf_rot_c%0d: got %h want %h",
                          j, display_data, model_disp());
      end
    end
    bus_op(1'b1, 1'b0, 3'd4, 16'h00AA, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd7, 16'h0000, ackv, rv);
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h0020) begin
      n_bad++; $display("FAIL clr_status: got %h want 0020", rv);
    end
  endtask

  task automatic test_random();
    logic ackv;
    logic [15:0] rv, exp, d;
    logic [2:0]  a;
    int op;
    bus_op(1'b1, 1'b0, 3'd0, 16'h000F, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd7, 16'h0000, ackv, rv);
    bus_op(1'b1, 1'b0, 3'd5, 16'h0000, ackv, rv);
    for (int i = 0; i < 120; i++) begin
      a  = 3'($urandom_range(0, 7));
      d  = 16'($urandom);
      op = $urandom_range(0, 2);
      if (a == 3'd5) d = 16'h0;
      if (a == 3'd7 && $urandom_range(0, 2) != 0) a = 3'd4;
      exp = model_read(a);
      bus_op(op != 1, op != 0, a, d, ackv, rv);
      n_cmp++;
      if (ackv !== 1'b1 || (op != 0 && rv !== exp)) begin
        n_bad++; $display("FAIL rnd_rd%0d a=%0d: got ack=%b %h want 1 %h",
                          i, a, ackv, rv, exp);
      end
      tick();
      n_cmp++;
      if (display_data !== model_disp() || pwm_period !== m_pwm
          || brightness !== m_ctrl[3:2] || display_mode !== m_ctrl[1:0])
      begin
        n_bad++;
        $display("FAIL rnd_out%0d: got %h %h %b %b want %h %h %b %b",
                 i, display_data, pwm_period, brightness, display_mode,
                 model_disp(), m_pwm, m_ctrl[3:2], m_ctrl[1:0]);
      end
    end
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== model_status()) begin
      n_bad++; $display("FAIL rnd_status: got %h want %h",
                        rv, model_status());
    end
  endtask

  task automatic test_async_reset();
    logic ackv;
    logic [15:0] rv;
    bus_op(1'b1, 1'b0, 3'd1, 16'h1234, ackv, rv);
    setup_scroll(16'd4);
    repeat (6) tick();
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.addr  = 3'd2;
    bus.wdata = 16'h5555;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (display_data !== 32'h0 || pwm_period !== 16'h0) begin
      n_bad++; $display("FAIL arst_out: got %h %h want 0 0",
                        display_data, pwm_period);
    end
    n_cmp++;
    if (display_mode !== 2'b11 || brightness !== 2'b11) begin
      n_bad++; $display("FAIL arst_mode: got %b %b want 11 11",
                        display_mode, brightness);
    end
    n_cmp++;
    if (bus.ack !== 1'b0) begin
      n_bad++; $display("FAIL arst_ack: got %b want 0", bus.ack);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    bus_op(1'b0, 1'b1, 3'd6, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h0020) begin
      n_bad++; $display("FAIL arst_status: got %h want 0020", rv);
    end
    bus_op(1'b0, 1'b1, 3'd0, 16'h0, ackv, rv);
    n_cmp++;
    if (rv !== 16'h000F) begin
      n_bad++; $display("FAIL arst_ctrl: got %h want 000F", rv);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    test_reset();
    test_hex();
    test_raw();
    test_rw_same();
    test_scroll();
    test_sdiv_zero();
    test_overflow();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
